// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: arbitrates the unified instruction/data memory between
// instruction fetch (IF) and load/store (DM). One transaction is in flight at a
// time: IDLE -> BUSY (MEM_LATENCY cycles) -> RESP (one-cycle ack) -> IDLE.
// All memory-side and requester-side outputs come straight from flops.
module mem_access_sequencer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction fetch requester
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  // load/store requester
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ack,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  // memory macro
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t                state_q,     state_d;
  logic [CW-1:0]         cnt_q,       cnt_d;
  logic                  owner_dm_q,  owner_dm_d;   // 1: DM owns the access
  logic                  store_q,     store_d;      // in-flight access is a store
  logic                  last_dm_q,   last_dm_d;    // last completed grant was DM
  logic                  if_ack_q,    if_ack_d;
  logic                  dm_ack_q,    dm_ack_d;
  logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q,  dm_rdata_d;
  logic                  mem_re_q,    mem_re_d;
  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  grant_dm;

  // DM wins unless IF is also requesting and DM had the previous grant.
  always_comb begin
    grant_dm = dm_req & ~(if_req & last_dm_q);
  end

  // Next-state and next-output computation for the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_dm_d  = owner_dm_q;
    store_d     = store_q;
    last_dm_d   = last_dm_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (if_req | dm_req) begin
          owner_dm_d  = grant_dm;
          store_d     = grant_dm & dm_we;
          mem_addr_d  = grant_dm ? dm_addr : if_addr;
          mem_wdata_d = (grant_dm & dm_we) ? dm_wdata : '0;
          // strobes are set here so they are already high in the first BUSY cycle
          mem_re_d    = ~(grant_dm & dm_we);
          mem_we_d    = grant_dm & dm_we;
          cnt_d       = CW'(MEM_LATENCY - 1);
          state_d     = BUSY;
        end
      end

      BUSY: begin
        if (cnt_q == '0) begin
          mem_re_d = 1'b0;
          state_d  = RESP;
          if (owner_dm_q) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = store_q ? '0 : mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      RESP: begin
        last_dm_d = owner_dm_q;
        state_d   = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_re_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_dm_q  <= 1'b0;
      store_q     <= 1'b0;
      last_dm_q   <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_dm_q  <= owner_dm_d;
      store_q     <= store_d;
      last_dm_q   <= last_dm_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Testbench for mem_access_sequencer: directed scenarios on a MEM_LATENCY=2
// instance, a single load on a MEM_LATENCY=1 instance, and a randomized run
// checked against a timeline/scoreboard reference model.
module tb_mem_access_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // MEM_LATENCY=2 instance signals
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic          if_ack, dm_ack, mem_re, mem_we;

  // MEM_LATENCY=1 instance signals
  logic          if_req_1, dm_req_1, dm_we_1;
  logic [AW-1:0] if_addr_1, dm_addr_1, mem_addr_1;
  logic [DW-1:0] dm_wdata_1, if_rdata_1, dm_rdata_1, mem_wdata_1, mem_rdata_1;
  logic          if_ack_1, dm_ack_1, mem_re_1, mem_we_1;

  int checks = 0;
  int errors = 0;

  mem_access_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_access_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut_1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_ack(if_ack_1), .if_rdata(if_rdata_1),
    .dm_req(dm_req_1), .dm_we(dm_we_1), .dm_addr(dm_addr_1), .dm_wdata(dm_wdata_1),
    .dm_ack(dm_ack_1), .dm_rdata(dm_rdata_1),
    .mem_re(mem_re_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1)
  );

  // Memory macro model: 16 words indexed by addr[5:2], unwritten words read a fixed pattern.
  function automatic logic [DW-1:0] init_word(input logic [3:0] i);
    case (i)
      4'd0:    return 32'h0000_0055;
      4'd1:    return 32'h0000_0093;
      4'd2:    return 32'h0000_0013;
      4'd5:    return 32'h1234_5678;
      default: return 32'hA5A5_0000 | {28'd0, i};
    endcase
  endfunction

  logic [DW-1:0] mac_mem [16];
  bit            wr_valid [16];
  int            re_cnt = 0;
  logic [3:0]    ridx;

  always @(posedge clk) begin
    re_cnt <= mem_re ? re_cnt + 1 : 0;
    if (mem_we) begin
      mac_mem[mem_addr[5:2]]  <= mem_wdata;
      wr_valid[mem_addr[5:2]] <= 1'b1;
    end
  end

  // Read data is valid only in the cycle MEM_LATENCY after issue; junk otherwise.
  always_comb begin
    ridx      = mem_addr[5:2];
    mem_rdata = 32'hDEAD_0BAD;
    if (mem_re && re_cnt == L - 1)
      mem_rdata = wr_valid[ridx] ? mac_mem[ridx] : init_word(ridx);
  end

  assign mem_rdata_1 = mem_re_1 ? init_word(mem_addr_1[5:2]) : 32'hDEAD_1BAD;

  // contention observations
  int            ack_who [8];
  int            ack_cyc [8];
  logic [DW-1:0] ack_rd  [8];
  int            got, overlap;

  task automatic reset_dut();
    @(negedge clk);
    rst_n  = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one request on the L=2 instance and observe it until ack (bounded).
  task automatic run_one(input bit is_dm, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, output int ack_at, output int re_n,
                         output int we_n, output logic [DW-1:0] rd,
                         output logic [AW-1:0] r_addr, output logic [AW-1:0] w_addr,
                         output logic [DW-1:0] w_data);
    ack_at = -1; re_n = 0; we_n = 0; rd = '0; r_addr = '0; w_addr = '0; w_data = '0;
    @(negedge clk);
    if (is_dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 1; i <= 20 && ack_at < 0; i++) begin
      @(posedge clk); #1;
      if (mem_re) begin re_n++; r_addr = mem_addr; end
      if (mem_we) begin we_n++; w_addr = mem_addr; w_data = mem_wdata; end
      if (is_dm ? dm_ack : if_ack) begin
        ack_at = i;
        rd = is_dm ? dm_rdata : if_rdata;
      end
    end
    @(negedge clk);
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  // Both requesters held high until n acks are collected (bounded).
  task automatic run_contended(input int n);
    got = 0; overlap = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0008;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1000_0000;
    for (int i = 1; i <= 60 && got < n; i++) begin
      @(posedge clk); #1;
      if (if_ack && dm_ack) overlap++;
      if (if_ack || dm_ack) begin
        ack_who[got] = dm_ack ? 1 : 0;
        ack_cyc[got] = i;
        ack_rd[got]  = dm_ack ? dm_rdata : if_rdata;
        got++;
      end
    end
    @(negedge clk);
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [4*DW+4-1:0] outs;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    if_req_1 = 1'b0; if_addr_1 = '0; dm_req_1 = 1'b0; dm_we_1 = 1'b0;
    dm_addr_1 = '0; dm_wdata_1 = '0;
    repeat (2) @(negedge clk);
    outs = {if_ack, dm_ack, mem_re, mem_we, if_rdata, dm_rdata, mem_addr, mem_wdata};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (mem_re !== 1'b1) begin
      errors++; $display("FAIL reset_pre_busy_re: got %b expected 1", mem_re);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {if_ack, dm_ack, mem_re, mem_we, if_rdata, dm_rdata, mem_addr, mem_wdata};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_mid_busy: got %h expected 0", outs);
    end
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({mem_re, mem_we, if_ack, dm_ack} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle_after: got %b expected 0000", {mem_re, mem_we, if_ack, dm_ack});
      end
    end
  endtask

  task automatic test_single_fetch();
    int ack_at, re_n, we_n;
    logic [DW-1:0] rd, w_data;
    logic [AW-1:0] r_addr, w_addr;
    run_one(1'b0, 1'b0, 32'h0000_0004, '0, ack_at, re_n, we_n, rd, r_addr, w_addr, w_data);
    checks++;
    if (ack_at !== 3) begin errors++; $display("FAIL fetch_ack_cycle: got %0d expected 3", ack_at); end
    checks++;
    if (re_n !== 2) begin errors++; $display("FAIL fetch_re_cycles: got %0d expected 2", re_n); end
    checks++;
    if (we_n !== 0) begin errors++; $display("FAIL fetch_we_cycles: got %0d expected 0", we_n); end
    checks++;
    if (rd !== 32'h0000_0093) begin errors++; $display("FAIL fetch_rdata: got %h expected 00000093", rd); end
    checks++;
    if (r_addr !== 32'h0000_0004) begin errors++; $display("FAIL fetch_addr: got %h expected 00000004", r_addr); end
  endtask

  task automatic test_store();
    int ack_at, re_n, we_n;
    logic [DW-1:0] rd, w_data;
    logic [AW-1:0] r_addr, w_addr;
    run_one(1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, ack_at, re_n, we_n, rd, r_addr, w_addr, w_data);
    checks++;
    if (ack_at !== 3) begin errors++; $display("FAIL store_ack_cycle: got %0d expected 3", ack_at); end
    checks++;
    if (we_n !== 1) begin errors++; $display("FAIL store_we_cycles: got %0d expected 1", we_n); end
    checks++;
    if (re_n !== 0) begin errors++; $display("FAIL store_re_cycles: got %0d expected 0", re_n); end
    checks++;
    if (w_addr !== 32'h1000_0010 || w_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL store_addr_data: got %h/%h expected 10000010/deadbeef", w_addr, w_data);
    end
    checks++;
    if (rd !== '0) begin errors++; $display("FAIL store_rdata: got %h expected 0", rd); end
    // read back the stored word as a load
    run_one(1'b1, 1'b0, 32'h1000_0010, '0, ack_at, re_n, we_n, rd, r_addr, w_addr, w_data);
    checks++;
    if (ack_at !== 3 || rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL store_readback: got ack %0d data %h expected ack 3 data deadbeef", ack_at, rd);
    end
  endtask

  task automatic test_contention();
    reset_dut();
    run_contended(2);
    checks++;
    if (got !== 2) begin errors++; $display("FAIL contention_acks: got %0d expected 2", got); end
    checks++;
    if (ack_who[0] !== 1 || ack_rd[0] !== 32'h0000_0055 || ack_cyc[0] !== 3) begin
      errors++;
      $display("FAIL contention_first: got who %0d data %h cyc %0d expected DM 00000055 3",
               ack_who[0], ack_rd[0], ack_cyc[0]);
    end
    checks++;
    if (ack_who[1] !== 0 || ack_rd[1] !== 32'h0000_0013) begin
      errors++; $display("FAIL contention_second: got who %0d data %h expected IF 00000013", ack_who[1], ack_rd[1]);
    end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL contention_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_alternation();
    reset_dut();
    run_contended(4);
    checks++;
    if (got !== 4) begin errors++; $display("FAIL alt_acks: got %0d expected 4", got); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ack_who[k] !== ((k % 2 == 0) ? 1 : 0)) begin
        errors++; $display("FAIL alt_order[%0d]: got %0d expected %0d", k, ack_who[k], (k % 2 == 0) ? 1 : 0);
      end
      if (k > 0) begin
        checks++;
        if (ack_cyc[k] - ack_cyc[k-1] !== L + 2) begin
          errors++; $display("FAIL alt_spacing[%0d]: got %0d expected %0d", k, ack_cyc[k] - ack_cyc[k-1], L + 2);
        end
      end
    end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL alt_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_latency1();
    int ack_at, re_n;
    logic [DW-1:0] rd;
    ack_at = -1; re_n = 0; rd = '0;
    @(negedge clk);
    dm_req_1 = 1'b1; dm_we_1 = 1'b0; dm_addr_1 = 32'h0000_0014;
    for (int i = 1; i <= 10 && ack_at < 0; i++) begin
      @(posedge clk); #1;
      if (mem_re_1) re_n++;
      if (dm_ack_1) begin ack_at = i; rd = dm_rdata_1; end
    end
    @(negedge clk);
    dm_req_1 = 1'b0;
    checks++;
    if (ack_at !== 2) begin errors++; $display("FAIL lat1_ack_cycle: got %0d expected 2", ack_at); end
    checks++;
    if (re_n !== 1) begin errors++; $display("FAIL lat1_busy_cycles: got %0d expected 1", re_n); end
    checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL lat1_rdata: got %h expected 12345678", rd); end
  endtask

  // Randomized traffic vs. a timeline model: a grant at sampling edge g makes the
  // strobe(s) visible after edges g..g+L-1, the ack after edge g+L, and the
  // arbiter is next able to sample at edge g+L+2.
  task automatic test_random(input int ncyc);
    logic [DW-1:0] ref_mem [16];
    int            g, free_at, e;
    bit            last_dm, own_dm, own_st, exp_re, exp_we, exp_ack;
    bit            if_pend, dm_pend, seen_if, seen_dm;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wd, exp_rd;
    reset_dut();
    for (int i = 0; i < 16; i++) ref_mem[i] = wr_valid[i] ? mac_mem[i] : init_word(4'(i));
    g = -100; free_at = 0; e = 0; last_dm = 1'b0;
    own_dm = 1'b0; own_st = 1'b0; own_addr = '0; own_wd = '0; exp_rd = '0;
    if_pend = 1'b0; dm_pend = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      if (e >= free_at && (if_req || dm_req)) begin
        own_dm   = dm_req && !(if_req && last_dm);
        own_st   = own_dm && dm_we;
        own_addr = own_dm ? dm_addr : if_addr;
        own_wd   = dm_wdata;
        if (own_st) begin
          ref_mem[own_addr[5:2]] = dm_wdata;
          exp_rd = '0;
        end else begin
          exp_rd = ref_mem[own_addr[5:2]];
        end
        g = e;
        free_at = e + L + 2;
      end
      #1;
      exp_re  = (e >= g) && (e <= g + L - 1) && !own_st;
      exp_we  = (e == g) && own_st;
      exp_ack = (e == g + L);
      checks++;
      if ({mem_re, mem_we} !== {exp_re, exp_we}) begin
        errors++; $display("FAIL rand_strobes@%0d: got %b%b expected %b%b", e, mem_re, mem_we, exp_re, exp_we);
      end
      checks++;
      if ({if_ack, dm_ack} !== {exp_ack && !own_dm, exp_ack && own_dm}) begin
        errors++;
        $display("FAIL rand_acks@%0d: got %b%b expected %b%b", e, if_ack, dm_ack, exp_ack && !own_dm, exp_ack && own_dm);
      end
      if (exp_re || exp_we) begin
        checks++;
        if (mem_addr !== own_addr) begin
          errors++; $display("FAIL rand_addr@%0d: got %h expected %h", e, mem_addr, own_addr);
        end
      end
      if (exp_we) begin
        checks++;
        if (mem_wdata !== own_wd) begin
          errors++; $display("FAIL rand_wdata@%0d: got %h expected %h", e, mem_wdata, own_wd);
        end
      end
      if (exp_ack) begin
        checks++;
        if ((own_dm ? dm_rdata : if_rdata) !== exp_rd) begin
          errors++; $display("FAIL rand_rdata@%0d: got %h expected %h", e, own_dm ? dm_rdata : if_rdata, exp_rd);
        end
        last_dm = own_dm;
      end
      seen_if = if_ack;
      seen_dm = dm_ack;
      e++;
      @(negedge clk);
      if (if_pend && seen_if) if_pend = 1'b0;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        if_addr = ($urandom & 32'hFFFF_FFC0) | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if_req = if_pend;
      if (dm_pend && seen_dm) dm_pend = 1'b0;
      if (!dm_pend && $urandom_range(0, 2) == 0) begin
        dm_pend  = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = ($urandom & 32'hFFFF_FFC0) | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        dm_wdata = $urandom;
      end
      dm_req = dm_pend;
    end
    @(negedge clk);
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_alternation();
    test_latency1();
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
